// File: rtl/neural_layer_seq_ctrl.sv
// neural_layer_seq_ctrl: runs one shared per-neuron datapath over every output of a layer, one neuron at a time.
//   The input vector is latched when a start is accepted. For each neuron index 0..OUT_SIZE-1 the controller
//   waits DP_LATENCY+1 cycles, then stores the float32 dp_result into the matching slot of result.
//   Ports: clk, rst_n (async, active-low), start, in (IN_SIZE floats), dp_in, dp_idx, dp_valid,
//          dp_result, result (OUT_SIZE floats, element j at [32*j +: 32]), busy, done.
//   Optional macro NEURAL_SEQ_CTRL_ABORT_EN adds an abort input that cancels a run in progress.
module neural_layer_seq_ctrl #(
  parameter int IN_SIZE = 1,
  parameter int OUT_SIZE = 1,
  parameter int DP_LATENCY = 1,
  localparam int IDX_W = (OUT_SIZE > 2) ? $clog2(OUT_SIZE) : 1,
  localparam int CNT_W = (DP_LATENCY > 1) ? $clog2(DP_LATENCY + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
`ifdef NEURAL_SEQ_CTRL_ABORT_EN
  input  logic                    abort,
`endif
  input  logic [32*IN_SIZE-1:0]   in,
  output logic [32*IN_SIZE-1:0]   dp_in,
  output logic [IDX_W-1:0]        dp_idx,
  output logic                    dp_valid,
  input  logic [31:0]             dp_result,
  output logic [32*OUT_SIZE-1:0]  result,
  output logic                    busy,
  output logic                    done
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic kill;
`ifdef NEURAL_SEQ_CTRL_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  assign dp_valid = state == RUN;
  assign done = state == DONE;
  assign busy = (state == RUN) || (state == DONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dp_in <= '0;
      dp_idx <= '0;
      cnt <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          dp_in <= in;
          dp_idx <= '0;
          cnt <= '0;
        end
        RUN: if (kill) begin
          // cancelled run keeps whatever elements were already stored
          state <= IDLE;
          dp_idx <= '0;
          cnt <= '0;
        end else if (cnt != CNT_W'(DP_LATENCY)) begin
          cnt <= cnt + 1'b1;
        end else begin
          result[32*dp_idx +: 32] <= dp_result;
          cnt <= '0;
          if (dp_idx == IDX_W'(OUT_SIZE - 1)) state <= DONE;
          else dp_idx <= dp_idx + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          dp_idx <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neural_layer_seq_ctrl.sv
// tb_neural_layer_seq_ctrl: randomized self-checking bench for neural_layer_seq_ctrl against a table-based model.
module tb_neural_layer_seq_ctrl;
  localparam int N = 3, L = 2;
  logic clk = 0, rst_n = 0, start = 0, start1 = 0, abort = 0;
  logic [63:0] in = '0, dp_in;
  logic [1:0] dp_idx;
  logic dp_valid, busy, done;
  logic [31:0] dp_result, p1, p2;
  logic [95:0] result, model = '0;
  logic [31:0] in1 = '0, dp_in1, dp_result1, result1;
  logic dp_idx1, dp_valid1, busy1, done1;
  logic [31:0] rt [N];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    p1 <= rt[dp_idx];
    p2 <= p1;
  end
  assign dp_result = p2;
  assign dp_result1 = rt[dp_idx1];
  neural_layer_seq_ctrl #(.IN_SIZE(2), .OUT_SIZE(N), .DP_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef NEURAL_SEQ_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in(in), .dp_in(dp_in), .dp_idx(dp_idx), .dp_valid(dp_valid),
    .dp_result(dp_result), .result(result), .busy(busy), .done(done));
  neural_layer_seq_ctrl #(.IN_SIZE(1), .OUT_SIZE(1), .DP_LATENCY(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef NEURAL_SEQ_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .in(in1), .dp_in(dp_in1), .dp_idx(dp_idx1), .dp_valid(dp_valid1),
    .dp_result(dp_result1), .result(result1), .busy(busy1), .done(done1));
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fill_table;
    logic [31:0] sp [4] = '{32'h7FC00001, 32'h80000000, 32'h7F800000, 32'hFF800000};
    foreach (rt[j]) rt[j] = ($urandom % 4 == 0) ? sp[$urandom % 4] : $urandom;
  endtask
  task automatic wait_done;
    int e = 0;
    while (!done && e < 40) begin
      tick;
      e++;
    end
    chk("wait_done", done, 1);
    tick;
  endtask
  task automatic run(input logic [63:0] v, input bit hold, input bit wiggle);
    int e = 0;
    logic [63:0] lat = v;
    in = v;
    start = 1;
    do begin
      tick;
      e++;
      if (!hold) start = 0;
      if (!done) begin
        chk("dp_valid", dp_valid, 1);
        chk("dp_idx", dp_idx, 96'((e - 1) / (L + 1)));
        chk("dp_in", dp_in, lat);
        if (wiggle) in = {$urandom, $urandom};
      end
    end while (!done && e < 40);
    chk("done_lat", 96'(e), 96'(N * (L + 1) + 1));
    model = {rt[2], rt[1], rt[0]};
    chk("result", result, model);
    chk("busy_in_done", busy, 1);
    tick;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("idx_ret", dp_idx, 0);
    chk("result_hold", result, model);
  endtask
  initial begin
    logic [63:0] lat;
    int e;
    repeat (2) tick;
    rst_n = 1;
    repeat (5) tick;
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", dp_valid, 0);
    chk("rst_idx", dp_idx, 0);
    chk("rst_dp_in", dp_in, 0);
    foreach (rt[j]) rt[j] = 32'h3F800000 + j;
    run({32'h40000000, 32'h3F800000}, 0, 0);
    chk("directed_result", result, {32'h3F800002, 32'h3F800001, 32'h3F800000});
    fill_table;
    run({$urandom, $urandom}, 1, 1);
    lat = in;
    tick;
    chk("restart_valid", dp_valid, 1);
    chk("restart_dp_in", dp_in, lat);
    start = 0;
    wait_done;
    chk("restart_result", result, model);
    fill_table;
    in = {$urandom, $urandom};
    start = 1;
    tick;
    start = 0;
    repeat (3) tick;
    #1 rst_n = 0;
    #1;
    chk("arst_result", result, 0);
    chk("arst_dp_in", dp_in, 0);
    chk("arst_idx", dp_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", dp_valid, 0);
    chk("arst_done", done, 0);
    @(negedge clk) rst_n = 1;
    tick;
    run({$urandom, $urandom}, 0, 0);
    repeat (6) begin
      fill_table;
      run({$urandom, $urandom}, 0, 1'($urandom % 2));
    end
    for (int k = 0; k < 4; k++) begin
      rt[0] = (k == 0) ? 32'h3F800000 : $urandom;
      in1 = $urandom;
      start1 = 1;
      e = 0;
      do begin
        tick;
        e++;
        start1 = 0;
        if (!done1) begin
          chk("s_idx", dp_idx1, 0);
          chk("s_dp_in", dp_in1, in1);
        end
      end while (!done1 && e < 10);
      chk("s_done_lat", 96'(e), 2);
      chk("s_result", result1, rt[0]);
      tick;
    end
`ifdef NEURAL_SEQ_CTRL_ABORT_EN
    fill_table;
    in = {$urandom, $urandom};
    start = 1;
    tick;
    start = 0;
    repeat (3) tick;
    chk("ab_pre_idx", dp_idx, 1);
    abort = 1;
    tick;
    abort = 0;
    chk("ab_busy", busy, 0);
    chk("ab_valid", dp_valid, 0);
    chk("ab_done", done, 0);
    chk("ab_idx", dp_idx, 0);
    model[31:0] = rt[0];
    chk("ab_result", result, model);
    e = 0;
    repeat (12) begin
      tick;
      if (done) e++;
    end
    chk("ab_no_done", 96'(e), 0);
    abort = 1;
    start = 1;
    tick;
    abort = 0;
    start = 0;
    chk("ab_start_wins", dp_valid, 1);
    wait_done;
    model = {rt[2], rt[1], rt[0]};
    chk("ab_rerun_result", result, model);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
